// File: rtl/r8_local_threshold.sv
// Adaptive-threshold binariser fed by the radius-8 box-sum stage.
// Four-stage pipeline: clamp/latch, reciprocal multiply, mean and threshold, compare.
module r8_local_threshold #(
    parameter int OUT_COLS = 8,
    parameter int OUT_ROWS = 4,
    parameter int RECIP    = 58053,
    parameter int SHIFT    = 24,
    parameter int SUM_MAX  = 73695
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [16:0] sum_i,
    input  logic [7:0]  center_i,
    input  logic [7:0]  offset_i,
    output logic        valid_o,
    output logic [7:0]  pixel_o,
    output logic [7:0]  mean_o,
    output logic [9:0]  col_o,
    output logic [9:0]  row_o,
    output logic        eof_o,
    output logic        err_o
);

    localparam int FRAME = OUT_COLS * OUT_ROWS;
    localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME - 1);
    localparam logic [9:0]       LAST_COL  = 10'(OUT_COLS - 1);
    localparam logic [9:0]       LAST_ROW  = 10'(OUT_ROWS - 1);
    localparam logic [16:0]      SUM_MAX_V = 17'(SUM_MAX);
    localparam logic [32:0]      RECIP_V   = 33'(RECIP);

    logic [CNT_W-1:0] in_cnt;
    logic [7:0]       offset_reg;

    logic        s1_valid;
    logic [16:0] s1_sum;
    logic [7:0]  s1_center;
    logic [7:0]  s1_off;

    logic        s2_valid;
    logic [32:0] s2_prod;
    logic [7:0]  s2_center;
    logic [7:0]  s2_off;

    logic        s3_valid;
    logic [7:0]  s3_mean;
    logic [7:0]  s3_thr;
    logic [7:0]  s3_center;

    logic [7:0]  mean_c;
    logic [9:0]  nxt_col;
    logic [9:0]  nxt_row;

    // The offset travels with each pixel, so a back-to-back frame that
    // re-latches offset_reg cannot disturb pixels still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            offset_reg <= '0;
            err_o      <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_center  <= '0;
            s1_off     <= '0;
        end else begin
            s1_valid  <= valid_i;
            s1_sum    <= (sum_i > SUM_MAX_V) ? SUM_MAX_V : sum_i;
            s1_center <= center_i;
            s1_off    <= (in_cnt == '0) ? offset_i : offset_reg;
            if (valid_i) begin
                if (in_cnt == '0)
                    offset_reg <= offset_i;
                in_cnt <= (in_cnt == LAST_PIX) ? '0 : in_cnt + 1'b1;
                if (sum_i > SUM_MAX_V)
                    err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_center <= '0;
            s2_off    <= '0;
        end else begin
            s2_valid  <= s1_valid;
            s2_prod   <= {16'd0, s1_sum} * RECIP_V;
            s2_center <= s1_center;
            s2_off    <= s1_off;
        end
    end

    // RECIP overshoots 2^SHIFT/289 slightly; the error never crosses an integer over the legal sum range.
    always_comb begin
        mean_c = 8'(s2_prod >> SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid  <= 1'b0;
            s3_mean   <= '0;
            s3_thr    <= '0;
            s3_center <= '0;
        end else begin
            s3_valid  <= s2_valid;
            s3_mean   <= mean_c;
            s3_thr    <= (mean_c > s2_off) ? (mean_c - s2_off) : 8'd0;
            s3_center <= s2_center;
        end
    end

    // Output stage: data outputs hold across gaps, eof_o is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            pixel_o <= '0;
            mean_o  <= '0;
            col_o   <= '0;
            row_o   <= '0;
            eof_o   <= 1'b0;
            nxt_col <= '0;
            nxt_row <= '0;
        end else begin
            valid_o <= s3_valid;
            eof_o   <= s3_valid && (nxt_col == LAST_COL) && (nxt_row == LAST_ROW);
            if (s3_valid) begin
                pixel_o <= (s3_center > s3_thr) ? 8'hFF : 8'h00;
                mean_o  <= s3_mean;
                col_o   <= nxt_col;
                row_o   <= nxt_row;
                if (nxt_col == LAST_COL) begin
                    nxt_col <= '0;
                    nxt_row <= (nxt_row == LAST_ROW) ? 10'd0 : nxt_row + 10'd1;
                end else begin
                    nxt_col <= nxt_col + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_r8_local_threshold.sv
// Scoreboard bench for r8_local_threshold: a division-based model queues the
// expected pixel per input, a negedge monitor pops it when valid_o appears.
module tb_r8_local_threshold;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [16:0] sum_i;
    logic [7:0]  center_i;
    logic [7:0]  offset_i;
    logic        valid_o;
    logic [7:0]  pixel_o;
    logic [7:0]  mean_o;
    logic [9:0]  col_o;
    logic [9:0]  row_o;
    logic        eof_o;
    logic        err_o;

    typedef struct packed {
        logic [7:0] pix;
        logic [7:0] mean;
        logic [9:0] col;
        logic [9:0] row;
        logic       eof;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   eof_count = 0;
    int   m_cnt     = 0;
    int   m_off     = 0;

    r8_local_threshold dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .sum_i    (sum_i),
        .center_i (center_i),
        .offset_i (offset_i),
        .valid_o  (valid_o),
        .pixel_o  (pixel_o),
        .mean_o   (mean_o),
        .col_o    (col_o),
        .row_o    (row_o),
        .eof_o    (eof_o),
        .err_o    (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && eof_o && !valid_o) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL eof_without_valid: eof_o=1 valid_o=0 required eof_o=0");
        end
        if (!rst && valid_o) begin
            exp_t e;
            if (eof_o) eof_count++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_valid: valid_o=1 with empty scoreboard");
            end else begin
                e = sb.pop_front();
                if ({pixel_o, mean_o, col_o, row_o, eof_o} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL output: got pix=%h mean=%0d col=%0d row=%0d eof=%b, required pix=%h mean=%0d col=%0d row=%0d eof=%b",
                             pixel_o, mean_o, col_o, row_o, eof_o, e.pix, e.mean, e.col, e.row, e.eof);
                end
            end
        end
    end

    task automatic drive_px(input int s, input int c, input int o);
        int   sc, mean, thr;
        exp_t e;
        if (m_cnt == 0) m_off = o;
        sc   = (s > 73695) ? 73695 : s;
        mean = sc / 289;
        thr  = (mean > m_off) ? mean - m_off : 0;
        e.pix  = (c > thr) ? 8'hFF : 8'h00;
        e.mean = 8'(mean);
        e.col  = 10'(m_cnt % 8);
        e.row  = 10'(m_cnt / 8);
        e.eof  = (m_cnt == 31);
        sb.push_back(e);
        m_cnt = (m_cnt == 31) ? 0 : m_cnt + 1;
        valid_i  = 1'b1;
        sum_i    = 17'(s);
        center_i = 8'(c);
        offset_i = 8'(o);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        valid_i = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_off = 0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1; valid_i = 1'b0; sum_i = '0; center_i = '0; offset_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({valid_o, pixel_o, mean_o, col_o, row_o, eof_o, err_o} !== 39'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs: v=%b pix=%h mean=%0d col=%0d row=%0d eof=%b err=%b required all 0",
                         valid_o, pixel_o, mean_o, col_o, row_o, eof_o, err_o);
            end
        end
        @(posedge clk);
        #1;
        drive_px(28900, 101, 0);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("[TB] FAIL latency: valid_o after %0d cycles, required 4", lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_threshold();
        bit ok;
        do_reset(2);
        drive_px(28900, 101, 0);
        drive_px(28900, 100, 0);
        drive_px(28900, 255, 0);
        drive_px(28900, 0, 0);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL threshold_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_offset();
        bit ok;
        do_reset(2);
        drive_px(28900, 96, 5);
        drive_px(28900, 95, 5);
        drive_px(28900, 95, 200);
        drive_px(28900, 96, 200);
        do_reset(2);
        drive_px(28900, 0, 200);
        drive_px(28900, 1, 200);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL offset_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_mean_sweep();
        bit ok;
        do_reset(2);
        drive_px(288, 0, 0);
        drive_px(289, 0, 0);
        drive_px(73695, 0, 0);
        for (int s = 0; s <= 73695; s++)
            drive_px(s, 0, 0);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL sweep_drain: %0d pending, required 0", sb.size());
        end
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_legal: err_o=%b required 0", err_o);
        end
    endtask

    task automatic test_err();
        bit ok;
        drive_px(100000, 0, 0);
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_set: err_o=%b required 1", err_o);
        end
        drive_px(1000, 0, 0);
        wait_drain(ok);
        n_checks++;
        if (!ok || err_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_sticky: err_o=%b drained=%b required 1/1", err_o, ok);
        end
    endtask

    task automatic test_framing();
        bit ok;
        int eof0;
        do_reset(2);
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_cleared: err_o=%b required 0", err_o);
        end
        eof0 = eof_count;
        for (int p = 0; p < 64; p++)
            drive_px($urandom_range(73695), $urandom_range(255), (p < 32) ? 7 : 30 + p);
        wait_drain(ok);
        n_checks++;
        if (!ok || eof_count - eof0 != 2) begin
            n_fail++;
            $display("[TB] FAIL framing_eof: eof pulses=%0d drained=%b required 2/1", eof_count - eof0, ok);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int eof0;
        do_reset(2);
        for (int p = 0; p < 13; p++)
            drive_px($urandom_range(73695), $urandom_range(255), 12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        n_checks++;
        if ({valid_o, col_o, row_o} !== 21'd0) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset: v=%b col=%0d row=%0d required 0/0/0", valid_o, col_o, row_o);
        end
        @(posedge clk);
        #1;
        eof0 = eof_count;
        for (int p = 0; p < 32; p++)
            drive_px($urandom_range(73695), $urandom_range(255), 40);
        wait_drain(ok);
        n_checks++;
        if (!ok || eof_count - eof0 != 1) begin
            n_fail++;
            $display("[TB] FAIL midframe_eof: eof pulses=%0d drained=%b required 1/1", eof_count - eof0, ok);
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_offset();
        test_mean_sweep();
        test_err();
        test_framing();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
